serial_pattern_tx: RTL and testbench

- Serial bit-pattern transmitter: latches a programmable pattern of 1..MAX_LEN bits and shifts it out MSB-first (bit len-1 first), one bit per accepted transfer.
- Transfers use a valid/ready handshake.
- Generating end of the serial-bit sequence-detector datapath: drives the single-bit x input of downstream Moore detectors in the same clock domain.
- Supports one-shot and continuous-loop modes, abort, and a protocol-error flag.

---
 rtl/serial_pattern_tx.sv | 172 +++++++++++++++++
 tb/tb_serial_pattern_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: shifts a latched 1..MAX_LEN bit pattern out MSB-first.
// Latency: first valid bit one cycle after an accepted start; one bit per handshake, no bubbles.
// Backpressure: ready=0 holds the current bit indefinitely; abort in RUN drops straight to IDLE.
module serial_pattern_tx #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               loop,
  input  logic               abort,
  input  logic               ready,
  output logic               x_out,
  output logic               x_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Width-matched constants so length arithmetic stays in LEN_W bits.
  localparam logic [LEN_W-1:0] ONE_W     = LEN_W'(1);
  localparam logic [LEN_W-1:0] ZERO_W    = '0;
  localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

  // Registered state and outputs.
  state_t             state_q,   state_d;
  logic [MAX_LEN-1:0] pat_q,     pat_d;
  logic [LEN_W-1:0]   len_q,     len_d;
  logic [LEN_W-1:0]   idx_q,     idx_d;
  logic               loop_q,    loop_d;
  logic               x_out_q,   x_out_d;
  logic               x_valid_q, x_valid_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;
  logic               err_q,     err_d;

  // Bit select through a shift so the index may be wider than log2(MAX_LEN).
  function automatic logic bit_at(input logic [MAX_LEN-1:0] v, input logic [LEN_W-1:0] i);
    logic [MAX_LEN-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  logic len_legal;
  logic xfer;

  // A start is only honoured for 1 <= len <= MAX_LEN.
  always_comb begin
    len_legal = (len != ZERO_W) && (len <= MAX_LEN_W);
    xfer      = x_valid_q && ready;
  end

  // Next-state and next-output logic; every output is computed for the following cycle.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    idx_d     = idx_q;
    loop_d    = loop_q;
    x_out_d   = x_out_q;
    x_valid_d = x_valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        x_out_d   = 1'b0;
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
        if (start) begin
          if (len_legal) begin
            // Latch the request and present the MSB immediately.
            pat_d     = pattern;
            len_d     = len;
            loop_d    = loop;
            idx_d     = len - ONE_W;
            x_out_d   = bit_at(pattern, len - ONE_W);
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
            state_d   = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (abort) begin
          // Abort wins over a simultaneous handshake; the handshaked bit is still consumed.
          x_out_d   = 1'b0;
          x_valid_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else if (xfer) begin
          if (idx_q != ZERO_W) begin
            idx_d   = idx_q - ONE_W;
            x_out_d = bit_at(pat_q, idx_q - ONE_W);
          end else if (loop_q) begin
            // Wrap to the MSB with no idle cycle in between.
            idx_d   = len_q - ONE_W;
            x_out_d = bit_at(pat_q, len_q - ONE_W);
          end else begin
            x_out_d   = 1'b0;
            x_valid_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = ST_FIN;
          end
        end
      end

      ST_FIN: begin
        // Single done cycle; start and abort are ignored here.
        x_out_d   = 1'b0;
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        x_out_d   = 1'b0;
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      loop_q    <= 1'b0;
      x_out_q   <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      loop_q    <= loop_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign x_out   = x_out_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx with a bit scoreboard.
// Expected bits are queued at start and consumed on each observed handshake.
module tb_serial_pattern_tx;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               loop;
  logic               abort;
  logic               ready;
  logic               x_out;
  logic               x_valid;
  logic               busy;
  logic               done;
  logic               err;

  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  serial_pattern_tx #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .loop    (loop),
    .abort   (abort),
    .ready   (ready),
    .x_out   (x_out),
    .x_valid (x_valid),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic v, input logic b, input logic d, input logic e);
    chk1({tag, "_valid"}, x_valid, v);
    chk1({tag, "_busy"},  busy,    b);
    chk1({tag, "_done"},  done,    d);
    chk1({tag, "_err"},   err,     e);
  endtask

  // Called at a negedge with inputs settled: score the handshake the next edge will perform.
  task automatic cyc();
    logic e;
    if (x_valid === 1'b1 && ready === 1'b1) begin
      hs_cnt++;
      chkn("sb_nonempty", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk1("sb_bit", x_out, e);
      end
    end else if (x_valid !== 1'b1) begin
      chk1("x_out_zero_when_invalid", x_out, 1'b0);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_bits(input logic [MAX_LEN-1:0] p, input int l, input int reps);
    logic [MAX_LEN-1:0] tmp;
    for (int r = 0; r < reps; r++) begin
      for (int i = l - 1; i >= 0; i--) begin
        tmp = p >> i;
        exp_q.push_back(tmp[0]);
      end
    end
  endtask

  task automatic do_start(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic lp);
    pattern = p;
    len     = l;
    loop    = lp;
    start   = 1'b1;
    cyc();
    start   = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    pattern = '0;
    len     = '0;
    loop    = 1'b0;
    abort   = 1'b0;
    ready   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("reset_x", x_out, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    chk_outs("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic one-shot 0,1,1; start during FIN is ignored.
    push_bits(16'h0003, 3, 1);
    hs_cnt = 0;
    do_start(16'h0003, 5'd3, 1'b0);
    chk_outs("t1_c1", 1'b1, 1'b1, 1'b0, 1'b0);
    chk1("t1_c1_x", x_out, 1'b0);
    cyc();
    chk1("t1_c2_x", x_out, 1'b1);
    cyc();
    cyc();
    chk_outs("t1_fin", 1'b0, 1'b0, 1'b1, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk_outs("t1_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chkn("t1_q_empty", exp_q.size(), 0);
    chkn("t1_hs", hs_cnt, 3);
    cyc();
    chk_outs("t1_fin_start_ignored", 1'b0, 1'b0, 1'b0, 1'b0);

    // Stall with ready low in cycles 2-3.
    push_bits(16'h0003, 3, 1);
    hs_cnt = 0;
    do_start(16'h0003, 5'd3, 1'b0);
    chk1("t2_c1_x", x_out, 1'b0);
    cyc();
    ready = 1'b0;
    chk1("t2_c2_x", x_out, 1'b1);
    cyc();
    chk1("t2_c3_x", x_out, 1'b1);
    chk_outs("t2_c3", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc();
    ready = 1'b1;
    chk1("t2_c4_x", x_out, 1'b1);
    cyc();
    chk1("t2_c5_x", x_out, 1'b1);
    cyc();
    chk_outs("t2_fin", 1'b0, 1'b0, 1'b1, 1'b0);
    chkn("t2_hs", hs_cnt, 3);
    chkn("t2_q_empty", exp_q.size(), 0);
    cyc();

    // Loop mode, abort in cycle 7 while a handshake also happens.
    push_bits(16'h0003, 3, 4);
    hs_cnt = 0;
    do_start(16'h0003, 5'd3, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      chk_outs("t3_run", 1'b1, 1'b1, 1'b0, 1'b0);
      cyc();
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk_outs("t3_abort", 1'b0, 1'b0, 1'b0, 1'b0);
    chkn("t3_hs", hs_cnt, 7);
    chkn("t3_q_left", exp_q.size(), 5);
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      chk1("t3_no_done", done, 1'b0);
      cyc();
    end

    // Illegal lengths, then full-length pattern.
    do_start(16'hFFFF, 5'd0, 1'b0);
    chk_outs("t4_len0", 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    chk_outs("t4_len0_after", 1'b0, 1'b0, 1'b0, 1'b0);
    do_start(16'hFFFF, 5'd17, 1'b0);
    chk_outs("t4_len17", 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    chk_outs("t4_len17_after", 1'b0, 1'b0, 1'b0, 1'b0);
    push_bits(16'hA5C3, 16, 1);
    hs_cnt = 0;
    do_start(16'hA5C3, 5'd16, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      chk1("t4_busy", busy, 1'b1);
      cyc();
    end
    chk_outs("t4_fin", 1'b0, 1'b0, 1'b1, 1'b0);
    chkn("t4_hs", hs_cnt, 16);
    chkn("t4_q_empty", exp_q.size(), 0);
    cyc();

    // Start with new settings during RUN has no effect.
    push_bits(16'h00B4, 8, 1);
    hs_cnt = 0;
    do_start(16'h00B4, 5'd8, 1'b0);
    cyc();
    cyc();
    cyc();
    pattern = 16'hFFFF;
    len     = 5'd2;
    loop    = 1'b1;
    start   = 1'b1;
    cyc();
    start   = 1'b0;
    chk1("t5_no_err", err, 1'b0);
    for (int c = 0; c < 4; c++) cyc();
    chk_outs("t5_fin", 1'b0, 1'b0, 1'b1, 1'b0);
    chkn("t5_hs", hs_cnt, 8);
    chkn("t5_q_empty", exp_q.size(), 0);
    cyc();

    // Asynchronous reset mid-transfer.
    push_bits(16'h00FF, 8, 1);
    do_start(16'h00FF, 5'd8, 1'b0);
    cyc();
    cyc();
    #2 reset_n = 1'b0;
    #1;
    chk_outs("t5_async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("t5_async_rst_x", x_out, 1'b0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_outs("t5_after_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    push_bits(16'h0002, 2, 1);
    hs_cnt = 0;
    do_start(16'h0002, 5'd2, 1'b0);
    chk1("t5_new_x", x_out, 1'b1);
    cyc();
    cyc();
    chk_outs("t5_new_fin", 1'b0, 1'b0, 1'b1, 1'b0);
    chkn("t5_new_hs", hs_cnt, 2);
    cyc();

    // len=1 one-shot, then len=1 loop until abort.
    push_bits(16'h8001, 1, 1);
    hs_cnt = 0;
    do_start(16'h8001, 5'd1, 1'b0);
    chk_outs("t6_c1", 1'b1, 1'b1, 1'b0, 1'b0);
    chk1("t6_c1_x", x_out, 1'b1);
    cyc();
    chk_outs("t6_fin", 1'b0, 1'b0, 1'b1, 1'b0);
    chkn("t6_hs", hs_cnt, 1);
    cyc();
    push_bits(16'h8001, 1, 8);
    do_start(16'h8001, 5'd1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      chk1("t6_loop_v", x_valid, 1'b1);
      chk1("t6_loop_x", x_out, 1'b1);
      cyc();
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk_outs("t6_abort", 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.delete();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
